// File: rtl/mem_skew_pkg.sv
// Shared types and sizing helpers for the skewed systolic feed buffer.
// The step counter is sized so that it can hold ROWS+COLS-2.
package mem_skew_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int step_w(input int rows, input int cols);
    return (rows + cols > 2) ? $clog2(rows + cols) : 1;
  endfunction

endpackage

// File: rtl/mem_skew_row.sv
// One output channel: COLS-entry row storage and a skew-offset select.
// Channel OFFSET emits element (t - OFFSET), or zero outside the row.
module mem_skew_row #(
  parameter int BITS   = 8,
  parameter int COLS   = 8,
  parameter int OFFSET = 0,
  parameter int TW     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic signed [COLS-1:0][BITS-1:0] wdata,
  input  logic        [TW-1:0]          t,
  output logic signed [BITS-1:0]        sel
);

  logic [COLS-1:0][BITS-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem <= wdata;
    end
  end

  always_comb begin
    sel = '0;
    for (int j = 0; j < COLS; j++) begin
      if (j + OFFSET == int'(t)) begin
        sel = mem[j];
      end
    end
  end

endmodule

// File: rtl/mem_skew_buf.sv
// Row-loaded buffer streaming ROWS channels with a one-step skew per row.
// Define MEM_SKEW_ERR_EN to add the sticky err output.
module mem_skew_buf
  import mem_skew_pkg::*;
#(
  parameter int BITS = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ld_vld,
  input  logic        [$clog2(ROWS)-1:0]   ld_row,
  input  logic signed [COLS-1:0][BITS-1:0] ld_data,
  output logic                             ld_rdy,
  input  logic                             start,
  input  logic                             en,
  output logic signed [ROWS-1:0][BITS-1:0] dout,
  output logic                             dout_vld,
  output logic                             busy,
  output logic                             done
`ifdef MEM_SKEW_ERR_EN
  ,
  output logic                             err
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = step_w(ROWS, COLS);
  localparam logic [TW-1:0] LAST = TW'(ROWS + COLS - 2);
  localparam logic [RW:0] NROWS = (RW + 1)'(ROWS);

  state_t                    state;
  logic [TW-1:0]             t;
  logic [ROWS-1:0]           loaded;
  logic [ROWS-1:0][BITS-1:0] sel;
  logic                      row_ok;
  logic                      ld_acc;
  logic                      all_ld;

  assign busy   = (state == STREAM);
  assign ld_rdy = !busy;
  assign row_ok = {1'b0, ld_row} < NROWS;
  assign ld_acc = ld_vld && ld_rdy && row_ok;
  assign all_ld = &loaded;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    mem_skew_row #(
      .BITS  (BITS),
      .COLS  (COLS),
      .OFFSET(i),
      .TW    (TW)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (ld_acc && (ld_row == RW'(i))),
      .wdata(ld_data),
      .t    (t),
      .sel  (sel[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      loaded   <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      done     <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      done     <= 1'b0;
      if (ld_acc) begin
        loaded[ld_row] <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          // a same-cycle load wins over start
          if (start && all_ld && !ld_vld) begin
            state <= STREAM;
            t     <= '0;
          end
        end
        STREAM: begin
          if (en) begin
            dout     <= sel;
            dout_vld <= 1'b1;
            t        <= t + 1'b1;
            if (t == LAST) begin
              state  <= IDLE;
              done   <= 1'b1;
              loaded <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_SKEW_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((!busy && start && !all_ld) ||
                 (ld_vld && busy) ||
                 (ld_vld && !row_ok)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_skew_buf.sv
// Scoreboard bench for mem_skew_buf with ROWS=COLS=4, BITS=8.
// Expected stream steps are queued; a negedge monitor pops and compares.
module tb_mem_skew_buf;

  localparam int BITS = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [31:0] vec_t;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             ld_vld;
  logic        [1:0]                ld_row;
  logic signed [COLS-1:0][BITS-1:0] ld_data;
  logic                             ld_rdy;
  logic                             start;
  logic                             en;
  logic signed [ROWS-1:0][BITS-1:0] dout;
  logic                             dout_vld;
  logic                             busy;
  logic                             done;
`ifdef MEM_SKEW_ERR_EN
  logic                             err;
`endif

  always #5 clk = ~clk;

  mem_skew_buf #(
    .BITS(BITS),
    .ROWS(ROWS),
    .COLS(COLS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_vld  (ld_vld),
    .ld_row  (ld_row),
    .ld_data (ld_data),
    .ld_rdy  (ld_rdy),
    .start   (start),
    .en      (en),
    .dout    (dout),
    .dout_vld(dout_vld),
    .busy    (busy),
    .done    (done)
`ifdef MEM_SKEW_ERR_EN
    ,
    .err     (err)
`endif
  );

  // hand-computed steps for row[i][j] = 10*i + j, packed {r3,r2,r1,r0}
  localparam vec_t TBL [7] = '{
    32'h00000000, 32'h00000a01, 32'h00140b02, 32'h1e150c03,
    32'h1f160d00, 32'h20170000, 32'h21000000
  };

  logic signed [7:0] rows [4][4];
  vec_t exp_q [$];
  vec_t prev;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   d0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = '0;
    end else begin
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_step: got %h expected none", dout);
        end else begin
          chk("dout_step", dout, exp_q.pop_front());
        end
      end else begin
        chk("dout_hold", dout, prev);
      end
      if (done) done_cnt++;
      prev = dout;
    end
  end

  function automatic vec_t step_vec(input int t);
    vec_t v = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (t - i >= 0 && t - i < COLS) v[i*8 +: 8] = rows[i][t-i];
    end
    return v;
  endfunction

  task automatic load_row(input int r);
    @(posedge clk); #1;
    ld_vld = 1'b1;
    ld_row = 2'(r);
    for (int j = 0; j < COLS; j++) ld_data[j] = rows[r][j];
    chk("ld_rdy_idle", ld_rdy, 1);
    @(posedge clk); #1;
    ld_vld = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < ROWS; r++) load_row(r);
  endtask

  task automatic push_tbl();
    for (int k = 0; k < 7; k++) exp_q.push_back(TBL[k]);
  endtask

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(step_vec(k));
  endtask

  task automatic start_stream();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic pulse_start_ignored(input string nm);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk(nm, busy, 0);
  endtask

  task automatic run_to_end(input int base);
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk); #1;
    end
    chk("stream_end", busy, 0);
    @(negedge clk); #1;
    chk("done_pulses", done_cnt - base, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ld_vld  = 1'b0;
    ld_row  = '0;
    ld_data = '0;
    start   = 1'b0;
    en      = 1'b1;
    #12;
    chk("rst_ld_rdy", ld_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_done", done, 0);
`ifdef MEM_SKEW_ERR_EN
    chk("rst_err", err, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) rows[i][j] = 8'(10 * i + j);

    // basic full stream
    load_all();
    push_tbl();
    d0 = done_cnt;
    start_stream();
    run_to_end(d0);

    // incomplete mask: start ignored
    for (int r = 0; r < 3; r++) load_row(r);
    pulse_start_ignored("busy_partial_mask");
`ifdef MEM_SKEW_ERR_EN
    chk("err_partial_mask", err, 1);
`endif

    // load and start together: load wins, start next cycle streams
    push_tbl();
    d0 = done_cnt;
    @(posedge clk); #1;
    ld_vld = 1'b1;
    ld_row = 2'd3;
    for (int j = 0; j < COLS; j++) ld_data[j] = rows[3][j];
    start = 1'b1;
    @(posedge clk); #1;
    ld_vld = 1'b0;
    chk("busy_start_with_load", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_next", busy, 1);

    // stall 1,0,0,1 plus a rejected load during the stream
    @(posedge clk); #1;
    en      = 1'b0;
    ld_vld  = 1'b1;
    ld_row  = 2'd0;
    ld_data = {COLS{8'h63}};
    chk("ld_rdy_busy", ld_rdy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    en     = 1'b1;
    ld_vld = 1'b0;
    run_to_end(d0);

    // storage must be untouched by the rejected load
    load_all();
    push_tbl();
    d0 = done_cnt;
    start_stream();
    run_to_end(d0);

    // overwrite row 1, then abort with reset at step 3
    for (int j = 0; j < COLS; j++) rows[1][j] = 8'sd77;
    load_row(1);
    for (int j = 0; j < COLS; j++) rows[1][j] = 8'(-5 - j);
    load_all();
    push_model(4);
    d0 = done_cnt;
    start_stream();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_dout", dout, 0);
    chk("abort_dout_vld", dout_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ld_rdy", ld_rdy, 1);
    chk("abort_done", done, 0);
    chk("abort_queue", exp_q.size(), 0);
`ifdef MEM_SKEW_ERR_EN
    chk("abort_err", err, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);

    // mask cleared by reset: partial reload still refuses to start
    for (int r = 0; r < 3; r++) load_row(r);
    pulse_start_ignored("busy_after_abort");
    load_row(3);
    push_model(7);
    d0 = done_cnt;
    start_stream();
    run_to_end(d0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_skew_buf.md
MEM_SKEW_BUF -- requirements
Module: mem_skew_buf

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning signed element width.
REQ-002 SHALL have parameter ROWS, default 8, meaning output channel count (systolic rows).
REQ-003 SHALL have parameter COLS, default 8, meaning elements stored per row (stream length per channel).
REQ-004 Port clk  input  1: the single clock; all state on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port ld_vld  input  1: row-load request.
REQ-007 Port ld_row  input  $clog2(ROWS): target row index.
REQ-008 Port ld_data  input  signed [BITS] x COLS: row contents, element 0 streamed first.
REQ-009 Port ld_rdy  output  1: load accepted this cycle when ld_vld=1.
REQ-010 Port start  input  1: begin skewed stream.
REQ-011 Port en  input  1: advance stream one step.
REQ-012 Port dout  output  signed [BITS] x ROWS: registered skewed outputs.
REQ-013 Port dout_vld  output  1: dout holds a stream step.
REQ-014 Port busy  output  1: state is STREAM.
REQ-015 Port done  output  1: one-cycle pulse after final step.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM; counter t of width $clog2(ROWS+COLS).
REQ-017 ld_rdy SHALL equal !busy; load accepted when ld_vld && ld_rdy, writing ld_data into row ld_row and setting loaded[ld_row].
REQ-018 ld_row >= ROWS SHALL be ignored (no write, no mask change).
REQ-019 IDLE->STREAM SHALL occur on start=1 when loaded is all-ones and ld_vld=0; otherwise start ignored; t cleared to 0.
REQ-020 In STREAM, each edge with en=1: dout[i] <= row[i][t-i] if 0<=t-i<COLS else 0; dout_vld<=1; t<=t+1.
REQ-021 In STREAM with en=0: dout, t hold; dout_vld<=0.
REQ-022 Stream SHALL span ROWS+COLS-1 enabled steps; the edge performing step ROWS+COLS-2 SHALL return to IDLE, pulse done next cycle, clear loaded.
REQ-023 Outside STREAM dout SHALL hold last value and dout_vld SHALL be 0.
REQ-024 Stored row data SHALL be retained across streams; only loaded mask clears.
REQ-025 Reloading an already-loaded row in IDLE SHALL overwrite it.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, t=0, loaded=0, dout=0, dout_vld=0, done=0, busy=0, ld_rdy=1; row storage cleared to 0.
REQ-027 Reset mid-STREAM SHALL abort without done pulse.

Configuration
REQ-028 Macro MEM_SKEW_ERR_EN SHALL add output err (1 bit, sticky, cleared only by reset).
REQ-029 With MEM_SKEW_ERR_EN, err SHALL set on: start ignored due to incomplete mask; ld_vld while busy; ld_row >= ROWS.
REQ-030 Without MEM_SKEW_ERR_EN, port err and its logic SHALL be absent; function otherwise identical.

Structure
REQ-031 Package mem_skew_pkg SHALL hold the state enum typedef and a width helper for the step counter.
REQ-032 Sub-module mem_skew_row (one channel: COLS-entry storage, offset-select mux with parameter OFFSET=i) SHALL be instanced ROWS times via generate.

Verification (ROWS=COLS=4, BITS=8)
REQ-033 Load rows 0..3 with row[i][j]=10*i+j, start, en=1 continuous -> dout steps: {0,0,0,0}...; step0 {0,0,0,0}->dout={0,_,_,_} per REQ-020: step0 {0,0,0,0}, step1 {1,10,0,0}, step3 {3,12,21,30}, step6 {0,0,0,33}; done pulses once after 7 steps.
REQ-034 Load rows 0..2 only, start -> stays IDLE, busy=0; err=1 when macro defined.
REQ-035 Mid-stream en toggled 1,0,0,1 -> dout holds, dout_vld=0 on stalled cycles, total 7 valid steps.
REQ-036 ld_vld during STREAM -> ld_rdy=0, storage unchanged, next stream repeats identical data after full reload.
REQ-037 rst_n asserted at step 3 -> outputs zero asynchronously, no done, next start ignored until all rows reloaded.
REQ-038 ld_vld and start same cycle with 3 rows loaded, loading row 3 -> load accepted, start ignored; start next cycle enters STREAM.
